// File: rtl/frac_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : frac_div_sched
// Brief    : Sequencer for an N / N+0.5 clock divider. Owns the divide
//            counter, applies ratio changes only at period boundaries and
//            emits posedge-domain phase requests for the divider cell.
// Revision : 1.0  initial release
// ============================================================================
module frac_div_sched #(
    parameter int CNT_W    = 4,
    parameter int DEF_DIV  = 3,
    parameter int DEF_HALF = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CNT_W-1:0] cfg_div_i,
    input  logic             cfg_half_i,
    output logic             cfg_err_o,
    output logic [CNT_W:0]   div_cnt_o,
    output logic             period_start_o,
    output logic             ph_pos_o,
    output logic             ph_neg_o,
    output logic             active_o,
    output logic [CNT_W-1:0] cur_div_o,
    output logic             cur_half_o
);

    localparam logic [CNT_W-1:0] c_DEF_DIV  = CNT_W'(DEF_DIV);
    localparam logic             c_DEF_HALF = (DEF_HALF != 0);
    localparam logic [CNT_W-1:0] c_MIN_DIV  = CNT_W'(2);
    localparam logic [CNT_W:0]   c_CNT_ONE  = (CNT_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic             cur_half_q, cur_half_d;
    logic             pend_v_q, pend_v_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_half_q, pend_half_d;
    logic             cfg_err_q, cfg_err_d;
    logic             ph_pos_q, ph_pos_d;
    logic             ph_neg_q, ph_neg_d;
    logic             pstart_q, pstart_d;

    logic             active_w;
    logic             active_d_w;
    logic [CNT_W:0]   last_cnt_w;
    logic             at_last_w;
    logic             accept_w;
    logic             legal_w;
    logic [CNT_W:0]   half_n_w;
    logic [CNT_W:0]   neg_end_w;
    logic [CNT_W:0]   div_ext_w;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cur_div_q   <= c_DEF_DIV;
            cur_half_q  <= c_DEF_HALF;
            pend_v_q    <= 1'b0;
            pend_div_q  <= '0;
            pend_half_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            ph_pos_q    <= 1'b0;
            ph_neg_q    <= 1'b0;
            pstart_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_div_q   <= cur_div_d;
            cur_half_q  <= cur_half_d;
            pend_v_q    <= pend_v_d;
            pend_div_q  <= pend_div_d;
            pend_half_q <= pend_half_d;
            cfg_err_q   <= cfg_err_d;
            ph_pos_q    <= ph_pos_d;
            ph_neg_q    <= ph_neg_d;
            pstart_q    <= pstart_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_div_d   = cur_div_q;
        cur_half_d  = cur_half_q;
        pend_v_d    = pend_v_q;
        pend_div_d  = pend_div_q;
        pend_half_d = pend_half_q;

        active_w   = (state_q != S_IDLE);
        // Last count of the period: 2N for N+0.5, N-1 for integer N.
        last_cnt_w = cur_half_q ? {cur_div_q, 1'b0} : ({1'b0, cur_div_q} - c_CNT_ONE);
        at_last_w  = active_w && (cnt_q == last_cnt_w);
        accept_w   = cfg_valid_i && !pend_v_q;
        legal_w    = (cfg_div_i >= c_MIN_DIV);
        cfg_err_d  = accept_w && !legal_w;

        if (pend_v_q && ((state_q == S_IDLE) || at_last_w)) begin
            cur_div_d  = pend_div_q;
            cur_half_d = pend_half_q;
            pend_v_d   = 1'b0;
        end else if (accept_w && legal_w) begin
            if (state_q == S_IDLE) begin
                cur_div_d  = cfg_div_i;
                cur_half_d = cfg_half_i;
            end else begin
                pend_div_d  = cfg_div_i;
                pend_half_d = cfg_half_i;
                pend_v_d    = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = at_last_w ? '0 : (cnt_q + c_CNT_ONE);
                if (!en_i) begin
                    state_d = at_last_w ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_d = at_last_w ? '0 : (cnt_q + c_CNT_ONE);
                if (en_i) begin
                    state_d = S_RUN;
                end else if (at_last_w) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Phase decode uses next-cycle ratio/count so outputs stay aligned with div_cnt.
        active_d_w = (state_d != S_IDLE);
        div_ext_w  = {1'b0, cur_div_d};
        half_n_w   = div_ext_w >> 1;
        neg_end_w  = div_ext_w + half_n_w;
        ph_pos_d   = active_d_w && (cnt_d < half_n_w);
        ph_neg_d   = active_d_w && cur_half_d && (cnt_d >= div_ext_w) && (cnt_d < neg_end_w);
        pstart_d   = active_d_w && (cnt_d == '0);
    end

    assign cfg_ready_o    = !pend_v_q;
    assign cfg_err_o      = cfg_err_q;
    assign div_cnt_o      = cnt_q;
    assign period_start_o = pstart_q;
    assign ph_pos_o       = ph_pos_q;
    assign ph_neg_o       = ph_neg_q;
    assign active_o       = (state_q != S_IDLE);
    assign cur_div_o      = cur_div_q;
    assign cur_half_o     = cur_half_q;

endmodule
`default_nettype wire
